// File: rtl/maxpool_2x2_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pool stage.
// State encoding, read-beat count and signed int8 max.
package maxpool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MAX,
    WR,
    FIN
  } mp_state_e;

  localparam int RD_BEATS = 4;

  function automatic logic [7:0] smax8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return ($signed(b) > $signed(a)) ? b : a;
  endfunction

endpackage

// File: rtl/maxpool_2x2_if.sv
// Control and SRAM bus bundle of the max-pool stage.
// master = pooling engine, slave = controller plus both SRAMs.
interface maxpool_2x2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROW_W  = 6,
  parameter int CH_W   = 9
);

  logic              start;
  logic [ROW_W-1:0]  num_row;
  logic [CH_W-1:0]   num_ch;
  logic              busy;
  logic              finish;
  logic              in_cs;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_rdata;
  logic              out_cs;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_wdata;

  modport master (
    input  start,
    input  num_row,
    input  num_ch,
    input  in_rdata,
    output busy,
    output finish,
    output in_cs,
    output in_addr,
    output out_cs,
    output out_we,
    output out_addr,
    output out_wdata
  );

  modport slave (
    output start,
    output num_row,
    output num_ch,
    output in_rdata,
    input  busy,
    input  finish,
    input  in_cs,
    input  in_addr,
    input  out_cs,
    input  out_we,
    input  out_addr,
    input  out_wdata
  );

endinterface

// File: rtl/maxpool_2x2_addr_gen.sv
// Channel / pooled-row / pooled-column walker for the max-pool stage.
// Addresses reflect the post-advance position so WR can preload the next read.
module maxpool_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int ROW_W  = 6,
  parameter int CH_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [ROW_W-1:0]  i_side,
  input  logic [CH_W-1:0]   i_num_ch,
  output logic [ADDR_W-1:0] o_in_base,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_last
);

  import maxpool_pkg::*;

  logic [CH_W-1:0]   r_ch;
  logic [ROW_W-1:0]  r_orow;
  logic [ROW_W-1:0]  r_ocol;
  logic [CH_W-1:0]   w_ch_n;
  logic [ROW_W-1:0]  w_orow_n;
  logic [ROW_W-1:0]  w_ocol_n;
  logic              w_col_wrap;
  logic              w_row_wrap;
  logic [ADDR_W-1:0] w_r;
  logic [ADDR_W-1:0] w_p;

  assign w_col_wrap = (r_ocol == i_side - ROW_W'(1));
  assign w_row_wrap = (r_orow == i_side - ROW_W'(1));
  assign o_last = w_col_wrap && w_row_wrap &&
                  (r_ch == i_num_ch - CH_W'(1));

  always_comb begin
    w_ch_n   = r_ch;
    w_orow_n = r_orow;
    w_ocol_n = r_ocol;
    if (i_clr) begin
      w_ch_n   = '0;
      w_orow_n = '0;
      w_ocol_n = '0;
    end else if (i_adv) begin
      if (w_col_wrap) begin
        w_ocol_n = '0;
        if (w_row_wrap) begin
          w_orow_n = '0;
          w_ch_n   = r_ch + CH_W'(1);
        end else begin
          w_orow_n = r_orow + ROW_W'(1);
        end
      end else begin
        w_ocol_n = r_ocol + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch   <= '0;
      r_orow <= '0;
      r_ocol <= '0;
    end else begin
      r_ch   <= w_ch_n;
      r_orow <= w_orow_n;
      r_ocol <= w_ocol_n;
    end
  end

  assign w_r = ADDR_W'(i_row);
  assign w_p = ADDR_W'(i_side);

  assign o_in_base = ADDR_W'(w_ch_n) * w_r * w_r
                   + ((ADDR_W'(w_orow_n) * w_r) << 1)
                   + (ADDR_W'(w_ocol_n) << 1);

  assign o_out_addr = ADDR_W'(w_ch_n) * w_p * w_p
                    + ADDR_W'(w_orow_n) * w_p
                    + ADDR_W'(w_ocol_n);

endmodule

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 int8 max pooling over a CHW map, SRAM to SRAM.
// Six cycles per pooled pixel: four reads, one reduce, one write.
module maxpool_2x2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROW_W  = 6,
  parameter int CH_W   = 9
) (
  input  logic         clk,
  input  logic         rst,
  maxpool_2x2_if.master bus
);

  import maxpool_pkg::*;

  mp_state_e         r_state;
  logic [1:0]        r_cnt;
  logic [ROW_W-1:0]  r_row;
  logic [ROW_W-1:0]  r_side;
  logic [CH_W-1:0]   r_nch;
  logic [7:0]        r_max;
  logic              r_busy;
  logic              r_finish;
  logic              r_in_cs;
  logic [ADDR_W-1:0] r_in_addr;
  logic              r_out_cs;
  logic              r_out_we;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_wdata;

  logic [ADDR_W-1:0] w_in_base;
  logic [ADDR_W-1:0] w_out_addr;
  logic              w_last;
  logic              w_adv;
  logic              w_clr;
  logic [7:0]        w_px;
  logic              w_unused_rdata;

  assign w_adv = (r_state == WR);
  assign w_clr = (r_state == FIN);
  assign w_px  = bus.in_rdata[7:0];
  assign w_unused_rdata = ^bus.in_rdata[DATA_W-1:8];

  // Offsets of the 2x2 window: 0, 1, R, R+1.
  function automatic logic [ADDR_W-1:0] rd_off(
    input logic [1:0]       c,
    input logic [ROW_W-1:0] r
  );
    return (c[1] ? ADDR_W'(r) : '0) + ADDR_W'(c[0]);
  endfunction

  maxpool_addr_gen #(
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W),
    .CH_W   (CH_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_adv      (w_adv),
    .i_row      (r_row),
    .i_side     (r_side),
    .i_num_ch   (r_nch),
    .o_in_base  (w_in_base),
    .o_out_addr (w_out_addr),
    .o_last     (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_row       <= '0;
      r_side      <= '0;
      r_nch       <= '0;
      r_max       <= '0;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
      r_in_cs     <= 1'b0;
      r_in_addr   <= '0;
      r_out_cs    <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_addr  <= '0;
      r_out_wdata <= '0;
    end else begin
      r_finish <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_row  <= bus.num_row;
            r_side <= bus.num_row >> 1;
            r_nch  <= bus.num_ch;
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (bus.num_row < ROW_W'(2) ||
                bus.num_ch == '0) begin
              r_state  <= FIN;
              r_finish <= 1'b1;
            end else begin
              r_state   <= RD;
              r_in_cs   <= 1'b1;
              r_in_addr <= '0;
            end
          end
        end
        RD: begin
          // Data of beat k arrives during beat k+1.
          if (r_cnt == 2'd1) begin
            r_max <= w_px;
          end else if (r_cnt != 2'd0) begin
            r_max <= smax8(r_max, w_px);
          end
          if (r_cnt == 2'(RD_BEATS - 1)) begin
            r_state   <= MAX;
            r_cnt     <= '0;
            r_in_cs   <= 1'b0;
            r_in_addr <= '0;
          end else begin
            r_cnt     <= r_cnt + 2'd1;
            r_in_addr <= w_in_base +
                         rd_off(r_cnt + 2'd1, r_row);
          end
        end
        MAX: begin
          r_out_wdata <= {{(DATA_W-8){1'b0}},
                          smax8(r_max, w_px)};
          r_out_addr  <= w_out_addr;
          r_out_cs    <= 1'b1;
          r_out_we    <= 1'b1;
          r_state     <= WR;
        end
        WR: begin
          r_out_cs <= 1'b0;
          r_out_we <= 1'b0;
          if (w_last) begin
            r_state  <= FIN;
            r_finish <= 1'b1;
          end else begin
            r_state   <= RD;
            r_in_cs   <= 1'b1;
            r_in_addr <= w_in_base;
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.finish    = r_finish;
  assign bus.in_cs     = r_in_cs;
  assign bus.in_addr   = r_in_addr;
  assign bus.out_cs    = r_out_cs;
  assign bus.out_we    = r_out_we;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_wdata = r_out_wdata;

endmodule

// File: doc/maxpool_2x2.md
Name: maxpool_2x2

Overview:
- Downstream neighbour of the 1x1 convolution stage.
- Reads the finished int8 feature map (CHW, one activation per 32-bit word, bits [7:0]) from the conv output SRAM.
- Performs 2x2 stride-2 max pooling per channel and writes the pooled map to a separate output SRAM.
- Raises finish for one cycle when the whole map is pooled.

Parameters:
- ADDR_W, 32, SRAM address width.
- DATA_W, 32, SRAM word width.
- ROW_W, 6, width of the num_row field.
- CH_W, 9, width of the num_ch field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; latches num_row/num_ch and begins pooling.
- num_row  in  ROW_W  input feature-map side length R.
- num_ch  in  CH_W  channel count C.
- busy  out  1  high from the cycle after start through the FIN cycle.
- finish  out  1  one-cycle pulse in FIN.
- in_cs  out  1  input SRAM chip select.
- in_addr  out  ADDR_W  input SRAM word address.
- in_rdata  in  DATA_W  input SRAM read data, valid one cycle after in_cs/in_addr.
- out_cs  out  1  output SRAM chip select.
- out_we  out  1  output SRAM write enable, active high; top level maps it to the SRAM's write-request encoding.
- out_addr  out  ADDR_W  output SRAM word address.
- out_wdata  out  DATA_W  output SRAM write data.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): all state returns to IDLE; all counters, addresses, the max register and all outputs clear to 0. No partial write completes after reset asserts.
- Configuration latched at start:
  - R := num_row, C := num_ch.
  - P := R>>1, the pooled side length (floor: for odd R the last row and column are dropped).
- start while busy is ignored.
- start with R<2 or C==0 goes IDLE->FIN directly: finish pulses, no SRAM access.
- Counters: ch (0..C-1), orow (0..P-1), ocol (0..P-1), cnt (0..3).
- Input base address: ch*R*R + 2*orow*R + 2*ocol.
- Read offsets by cnt: 0, 1, R, R+1.
- Output address: ch*P*P + orow*P + ocol.
- States:
  - IDLE: outputs low. start -> RD.
  - RD, 4 cycles (cnt 0..3): in_cs=1, in_addr=base+offset[cnt].
    - In_rdata for read k is sampled in the following cycle.
    - cnt==1: maxreg := in_rdata[7:0].
    - cnt 2..3: maxreg := smax(maxreg, in_rdata[7:0]).
    - cnt==3 -> MAX.
  - MAX, 1 cycle: out_wdata := {24'h0, smax(maxreg, in_rdata[7:0])}; out_addr registered. -> WR.
  - WR, 1 cycle: out_cs=1, out_we=1. Advance ocol; on wrap advance orow; on wrap advance ch.
    - Last (ch=C-1, orow=P-1, ocol=P-1) -> FIN, else -> RD.
  - FIN, 1 cycle: finish=1; all counters clear. -> IDLE.
- Comparison is signed 8-bit (smax). Equal values keep the earlier one; the result is identical either way.
- Throughput is 6 cycles per output pixel.
- Total cycles from start to finish = 6*C*P*P + 2 (IDLE->RD cycle and FIN cycle).
- in_cs and out_cs are never high in the same cycle.
- out_we is high only in WR.
- Address arithmetic is ADDR_W wide, unsigned, with no wrap for legal sizes (R<=63, C<=511).

Decomposition:
- Package maxpool_pkg:
  - state enum mp_state_e {IDLE, RD, MAX, WR, FIN}.
  - Constant RD_BEATS=4.
  - Function smax8 (signed 8-bit max).
- One sub-module, maxpool_addr_gen: holds the ch/orow/ocol counters and produces the input base address, output address and last flag. It is driven by an advance strobe from WR and a clear from FIN/rst.
- FSM, max register and SRAM drive stay in maxpool_2x2.

Test Plan:
- R=4, C=1, input 0..15 row-major -> 4 writes: addr0=5, addr1=7, addr2=13, addr3=15; finish at cycle 26 after start.
- R=2, C=1, inputs {0xF0,0x85,0xFE,0x80} (all negative) -> single write addr0=0x000000FE (-2 is the max).
- R=5, C=2 (odd R), ramp data -> P=2, 8 writes. Channel 1 writes land at out_addr 4..7 and read in_addr base 25. Row 4 and column 4 are never read.
- R=4, C=3, then start pulsed again while busy -> the second start is ignored; exactly 12 writes; a single finish pulse.
- rst asserted in the RD state of pixel 2 -> next edge: busy=0, in_cs=0, out_we=0, addresses 0. A new start then completes a normal run with correct results.
- num_row=1 or num_ch=0 -> finish 2 cycles after start; in_cs and out_cs never asserted.
